// File: rtl/dmi_bus_master.sv
// Memory-mapped DMI initiator: a small register window that turns bus writes
// into DMI requests and captures the responses, standing in for a JTAG DTM.
package dm;
    typedef enum logic [1:0] {
        DTM_NOP   = 2'h0,
        DTM_READ  = 2'h1,
        DTM_WRITE = 2'h2
    } dtm_op_e;

    typedef struct packed {
        logic [6:0]  addr;
        dtm_op_e     op;
        logic [31:0] data;
    } dmi_req_t;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } dmi_resp_t;
endpackage

module dmi_bus_master #(
    parameter int BusWidth = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_i,
    input  logic                  we_i,
    input  logic [BusWidth-1:0]   addr_i,
    input  logic [BusWidth/8-1:0] be_i,
    input  logic [BusWidth-1:0]   wdata_i,
    output logic [BusWidth-1:0]   rdata_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  dmi_rst_no,
    output logic                  dmi_req_valid_o,
    input  logic                  dmi_req_ready_i,
    output dm::dmi_req_t          dmi_req_o,
    input  logic                  dmi_resp_valid_i,
    output logic                  dmi_resp_ready_o,
    input  dm::dmi_resp_t         dmi_resp_i
);
    localparam int A = $clog2(BusWidth / 8);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_e;

    state_e        state, state_d;
    dm::dmi_req_t  req_q;
    logic [31:0]   data_q;
    logic [1:0]    resp_q;
    logic          err_q, ovr_q, done_q, rst_pulse_q;
    logic [BusWidth-1:0] rdata_q;

    logic [1:0]    idx;
    logic          busy, wr_data, wr_cmd, cmd_clr, rst_fire, ovr_set;
    logic          launch, resp_hs;
    logic [31:0]   status, rd_val;
    logic          unused_bits;

    assign idx      = addr_i[A+1:A];
    assign busy     = (state != IDLE);
    assign wr_data  = req_i & we_i & (idx == 2'd0);
    assign wr_cmd   = req_i & we_i & (idx == 2'd1);
    assign cmd_clr  = wr_cmd & wdata_i[31];
    assign rst_fire = wr_cmd & wdata_i[30] & ~busy;
    // Anything that would need the idle FSM, arriving while busy, is an overrun.
    assign ovr_set  = busy & (wr_data | (wr_cmd & (wdata_i[30] | ~wdata_i[31])));

    assign status = {17'b0, req_q.addr, 3'b0, ovr_q, resp_q, err_q, busy};

    always_comb begin
        rd_val = 32'h0;
        case (idx)
            2'd0:    rd_val = data_q;
            2'd1:    rd_val = status;
            default: rd_val = 32'h0;
        endcase
    end

    always_comb begin
        state_d = state;
        launch  = 1'b0;
        resp_hs = 1'b0;
        unique case (state)
            IDLE: if (wr_cmd && wdata_i[31:30] == 2'b00) begin
                launch  = 1'b1;
                state_d = REQ;
            end
            REQ:  if (dmi_req_ready_i) state_d = RESP;
            RESP: if (dmi_resp_valid_i) begin
                resp_hs = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_d;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            req_q       <= '0;
            data_q      <= '0;
            resp_q      <= '0;
            err_q       <= 1'b0;
            ovr_q       <= 1'b0;
            done_q      <= 1'b0;
            rst_pulse_q <= 1'b0;
            rdata_q     <= '0;
        end else begin
            done_q      <= resp_hs;
            rst_pulse_q <= rst_fire;
            if (wr_data && !busy)
                data_q <= wdata_i[31:0];
            else if (resp_hs && req_q.op == dm::DTM_READ)
                data_q <= dmi_resp_i.data;
            if (launch) begin
                req_q.addr <= wdata_i[6:0];
                req_q.op   <= wdata_i[8] ? dm::DTM_WRITE : dm::DTM_READ;
                req_q.data <= data_q;
            end
            if (resp_hs) resp_q <= dmi_resp_i.resp;
            // Clear first so a same-cycle event still leaves its sticky mark.
            if (cmd_clr) err_q <= 1'b0;
            if (resp_hs && dmi_resp_i.resp != 2'b00) err_q <= 1'b1;
            if (cmd_clr) ovr_q <= 1'b0;
            if (ovr_set) ovr_q <= 1'b1;
            if (req_i && !we_i) rdata_q <= BusWidth'(rd_val);
        end
    end

    assign rdata_o          = rdata_q;
    assign busy_o           = busy;
    assign done_o           = done_q;
    assign dmi_rst_no       = ~rst_pulse_q;
    assign dmi_req_valid_o  = (state == REQ);
    assign dmi_resp_ready_o = (state == RESP);
    assign dmi_req_o        = req_q;

    assign unused_bits = ^{be_i, addr_i, wdata_i};
endmodule

// File: tb/tb_dmi_bus_master.sv
// Scoreboard bench for dmi_bus_master: stimulus queues expected bus reads and
// DMI requests, a negedge monitor pops and compares them as the DUT presents them.
module tb_dmi_bus_master;
    logic          clk = 1'b0;
    logic          rst;
    logic          req, we;
    logic [31:0]   addr, wdata, rdata;
    logic [3:0]    be;
    logic          busy, done, dmi_rst_n, req_valid, req_ready, resp_valid, resp_ready;
    dm::dmi_req_t  dmi_req;
    dm::dmi_resp_t dmi_resp;

    always #5 clk = ~clk;

    dmi_bus_master #(.BusWidth(32)) dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .addr_i(addr), .be_i(be),
        .wdata_i(wdata), .rdata_o(rdata), .busy_o(busy), .done_o(done),
        .dmi_rst_no(dmi_rst_n), .dmi_req_valid_o(req_valid), .dmi_req_ready_i(req_ready),
        .dmi_req_o(dmi_req), .dmi_resp_valid_i(resp_valid), .dmi_resp_ready_o(resp_ready),
        .dmi_resp_i(dmi_resp)
    );

    int total = 0, bad = 0;
    int done_cnt = 0, rstlow_cnt = 0, vcnt = 0, last_vcnt = 0;
    logic [31:0]  exp_rd[$];
    dm::dmi_req_t exp_req[$];
    bit           exp_full[$];
    bit           rd_due = 0;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail(string name, logic [63:0] act);
        total++;
        bad++;
        $display("FAIL %s: got %0h expected nothing", name, act);
    endtask

    // Monitor: bus read data, DMI request contents/stability, pulse counters.
    always @(negedge clk) begin
        logic [40:0] a, e;
        if (rd_due) begin
            if (exp_rd.size() == 0) fail("rd_unexpected", rdata);
            else check("rdata", rdata, exp_rd.pop_front());
        end
        rd_due = req && !we && !rst;
        if (done) done_cnt++;
        if (!dmi_rst_n) rstlow_cnt++;
        if (req_valid) begin
            vcnt++;
            if (exp_req.size() == 0) fail("req_unexpected", dmi_req);
            else begin
                a = dmi_req;
                e = exp_req[0];
                if (!exp_full[0]) begin
                    a[31:0] = '0;
                    e[31:0] = '0;
                end
                check("dmi_req", a, e);
                if (req_ready) begin
                    last_vcnt = vcnt;
                    vcnt = 0;
                    void'(exp_req.pop_front());
                    void'(exp_full.pop_front());
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_wr(input logic [1:0] i, input logic [31:0] d);
        req = 1; we = 1; addr = {28'h0, i, 2'b00}; wdata = d;
        cyc();
        req = 0; we = 0;
    endtask

    task automatic bus_rd(input logic [1:0] i, input logic [31:0] e);
        exp_rd.push_back(e);
        req = 1; we = 0; addr = {28'h0, i, 2'b00};
        cyc();
        req = 0;
    endtask

    task automatic launch(input logic [31:0] cmd, input logic [31:0] dval);
        dm::dmi_req_t r;
        r.addr = cmd[6:0];
        r.op   = cmd[8] ? dm::DTM_WRITE : dm::DTM_READ;
        r.data = dval;
        exp_req.push_back(r);
        exp_full.push_back(cmd[8]);
        bus_wr(2'd1, cmd);
    endtask

    task automatic do_handshake(input int delay);
        int n = 0;
        req_ready = 0;
        repeat (delay) cyc();
        req_ready = 1;
        while (!req_valid && n < 20) begin
            cyc();
            n++;
        end
        if (!req_valid) fail("req_timeout", n);
        cyc();
        req_ready = 0;
    endtask

    task automatic do_response(input logic [31:0] d, input logic [1:0] r, input int delay);
        repeat (delay) cyc();
        resp_valid = 1;
        dmi_resp = '{data: d, resp: r};
        cyc();
        resp_valid = 0;
        check("done_pulse", done, 1);
        check("busy_after_resp", busy, 0);
        cyc();
        check("done_single", done, 0);
    endtask

    task automatic check_reset_outputs(string tag);
        check({tag, "_valid"}, req_valid, 0);
        check({tag, "_resp_ready"}, resp_ready, 0);
        check({tag, "_rst_n"}, dmi_rst_n, 1);
        check({tag, "_req"}, dmi_req, 0);
        check({tag, "_rdata"}, rdata, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, r0;
        rst = 1; req = 0; we = 0; addr = 0; be = 4'hf; wdata = 0;
        req_ready = 0; resp_valid = 0; dmi_resp = '0;
        repeat (2) cyc();
        check_reset_outputs("reset");
        rst = 0;
        cyc();
        bus_rd(2'd0, 32'h0);
        bus_rd(2'd1, 32'h0);

        // 1: read path, minimum latency
        launch(32'h011, 32'h0);
        do_handshake(0);
        do_response(32'h1, 2'd0, 0);
        bus_rd(2'd0, 32'h1);
        bus_rd(2'd1, 32'h1100);

        // 2: write path with backpressure
        bus_wr(2'd0, 32'h8000_0001);
        launch(32'h110, 32'h8000_0001);
        do_handshake(5);
        check("t2_valid_cycles", last_vcnt, 6);
        do_response(32'hDEAD_BEEF, 2'd0, 0);
        bus_rd(2'd0, 32'h8000_0001);
        bus_rd(2'd1, 32'h1000);

        // 3: error response is sticky until cleared
        launch(32'h012, 32'h0);
        do_handshake(0);
        do_response(32'h1234, 2'd2, 1);
        bus_rd(2'd1, 32'h120A);
        bus_rd(2'd0, 32'h1234);
        launch(32'h013, 32'h0);
        do_handshake(0);
        do_response(32'h55, 2'd0, 0);
        bus_rd(2'd1, 32'h1302);
        bus_wr(2'd1, 32'h8000_0000);
        bus_rd(2'd1, 32'h1300);

        // 4: overrun while busy
        launch(32'h014, 32'h0);
        bus_wr(2'd1, 32'h115);
        bus_wr(2'd0, 32'hAAAA_5555);
        do_handshake(0);
        do_response(32'h77, 2'd0, 0);
        bus_rd(2'd1, 32'h1410);
        bus_rd(2'd0, 32'h77);
        bus_wr(2'd1, 32'h8000_0000);
        bus_rd(2'd1, 32'h1400);

        // 5: DMI reset pulse in IDLE, rejected while busy
        r0 = rstlow_cnt;
        bus_wr(2'd1, 32'h4000_0000);
        check("t5_rst_low", dmi_rst_n, 0);
        check("t5_no_valid", req_valid, 0);
        cyc();
        check("t5_rst_high", dmi_rst_n, 1);
        check("t5_rst_cycles", rstlow_cnt - r0, 1);
        bus_rd(2'd1, 32'h1400);
        r0 = rstlow_cnt;
        launch(32'h016, 32'h77);
        bus_wr(2'd1, 32'h4000_0000);
        cyc();
        check("t5_no_pulse_busy", rstlow_cnt - r0, 0);
        do_handshake(0);
        do_response(32'h99, 2'd0, 0);
        bus_rd(2'd1, 32'h1610);
        bus_rd(2'd0, 32'h99);

        // 6: reset during RESP, late response ignored
        bus_wr(2'd1, 32'h8000_0000);
        launch(32'h017, 32'h0);
        do_handshake(0);
        check("t6_in_resp", resp_ready, 1);
        d0 = done_cnt;
        rst = 1;
        #1;
        check_reset_outputs("t6_async");
        cyc();
        rst = 0;
        cyc();
        resp_valid = 1;
        dmi_resp = '{data: 32'hBAD0_BAD0, resp: 2'd0};
        #1;
        check("t6_late_ready", resp_ready, 0);
        cyc();
        resp_valid = 0;
        repeat (2) cyc();
        check("t6_no_done", done_cnt - d0, 0);
        bus_rd(2'd1, 32'h0);
        bus_rd(2'd0, 32'h0);
        repeat (2) cyc();
        check("rd_queue_empty", exp_rd.size(), 0);
        check("req_queue_empty", exp_req.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
